// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   state_e : controller state encoding (IDLE / RUN / FLUSH)
//   WCNT_W  : width of the delivered-word counter
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int unsigned WCNT_W = 32;

endpackage

// File: rtl/fifo_rd_skid2.sv
// Two-entry FIFO-ordered skid buffer between the FIFO read port and the
// downstream stream.
//   clk, reset_ : clock, asynchronous active-low reset
//   clr         : discard all buffered words (wins over push/pop)
//   push        : write push_data at the tail
//   pop         : remove the head entry (only legal while out_valid=1)
//   out_valid   : buffer holds at least one word
//   out_data    : head entry
//   cnt         : number of buffered words (0..2)
module fifo_rd_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] e0_q, e0_d;  // head
  logic [WIDTH-1:0] e1_q, e1_d;  // tail when two words are held
  logic [1:0]       cnt_q, cnt_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data;
          else               e1_d = push_data;
          if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the head advances and the new word
          // lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage boundary: buffer storage
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the asynchronous FIFO, entirely in the read clock
// domain. Turns the FIFO's one-cycle registered read latency into a
// valid/ready stream with a start threshold, 2-entry skid buffer, flush and
// a delivered-word counter.
//   clk        : FIFO read clock
//   reset_     : asynchronous active-low reset
//   rden       : FIFO read request (combinational from registered state)
//   dataout    : FIFO read data, valid the cycle after rden
//   rdempty    : FIFO empty flag
//   rdusedw    : FIFO fill level
//   flush      : discard buffered words and drain the FIFO
//   out_valid / out_data / out_ready : downstream stream
//   busy       : controller not idle
//   word_cnt   : accepted-word count, wraps
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int PTR          = 4,
  parameter int START_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset_,
  output logic              rden,
  input  logic [WIDTH-1:0]  dataout,
  input  logic              rdempty,
  input  logic [PTR:0]      rdusedw,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [WCNT_W-1:0] word_cnt
);

  // A threshold above DEPTH can never be reached, so IDLE would never exit.
  if (START_THRESH < 1 || START_THRESH > DEPTH) begin : g_thresh_chk
    $error("fifo_rd_stream: START_THRESH must lie within 1..DEPTH");
  end

  localparam logic [PTR:0] THRESH = (PTR+1)'(START_THRESH);

  state_e            state_q, state_d;
  logic              rd_pend_q;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]        skid_cnt;
  logic              credit_ok;
  logic              hs;
  logic              push;
  logic              clr;

  // Registered-only credit: buffered plus in-flight words must leave room
  // for the word this read will return.
  assign credit_ok = ({1'b0, skid_cnt} + {2'b00, rd_pend_q}) < 3'd2;

  // FLUSH drains without a credit limit since returning words are dropped.
  assign rden = !rdempty &&
                (((state_q == ST_RUN) && credit_ok) || (state_q == ST_FLUSH));

  assign hs   = out_valid && out_ready;
  assign push = rd_pend_q && (state_q == ST_RUN);
  // Holding clear for the whole flush keeps the buffer empty on entry and
  // throughout.
  assign clr  = (state_d == ST_FLUSH);
  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q + WCNT_W'(hs);
    case (state_q)
      ST_IDLE: begin
        if (flush)                  state_d = ST_FLUSH;
        else if (rdusedw >= THRESH) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (flush)
          state_d = ST_FLUSH;
        else if (rdempty && !rd_pend_q && (skid_cnt == 2'd0))
          state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (rdempty && !rd_pend_q && !flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage boundary: controller state, in-flight flag, counter
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rden;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;

  fifo_rd_skid2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_    (reset_),
    .clr       (clr),
    .push      (push),
    .push_data (dataout),
    .pop       (hs),
    .out_valid (out_valid),
    .out_data  (out_data),
    .cnt       (skid_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic        clk;
  logic        reset_;
  logic        rden;
  logic [7:0]  dataout;
  logic        rdempty;
  logic [4:0]  rdusedw;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic [31:0] word_cnt;

  fifo_rd_stream #(
    .WIDTH(8), .DEPTH(16), .PTR(4), .START_THRESH(4)
  ) dut (
    .clk       (clk),
    .reset_    (reset_),
    .rden      (rden),
    .dataout   (dataout),
    .rdempty   (rdempty),
    .rdusedw   (rdusedw),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: storage written by the stimulus, read pointer advanced on
  // rden with one cycle of read latency.
  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rdempty = (wr_ptr == rd_ptr);
  assign rdusedw = 5'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (rden) begin
      dataout <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  // Reference: delivered stream equals FIFO contents in load order, minus
  // words that were flushed or lost to reset.
  logic [7:0]  exp_q[$];
  logic [31:0] exp_cnt = 0;
  int          rd_n = 0;
  int          hs_n = 0;
  bit          flushing = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = 0;

  always @(negedge clk) begin
    if (!reset_) begin
      exp_cnt    = 0;
      rd_n       = 0;
      hs_n       = 0;
      prev_stall = 0;
    end else begin
      chk("rden_while_empty", {31'd0, rden & rdempty}, 32'd0);
      chk("word_cnt", word_cnt, exp_cnt);
      if (prev_stall && !flushing) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (!flushing) begin
        if (rden) rd_n++;
        chk("outstanding", {31'd0, (rd_n - hs_n) <= 2}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", {24'd0, out_data}, 32'hFFFF_FFFF);
        else chk("data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
        exp_cnt++;
        hs_n++;
      end
      prev_stall = out_valid & !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'($urandom);
      exp_q.push_back(mem[wr_ptr]);
      wr_ptr++;
    end
  endtask

  // Returns right after the clock edge that consumed the last expected word.
  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int n_rem;

  initial begin
    reset_    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    dataout   = '0;
    #12;
    chk("rst_rden", {31'd0, rden}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", word_cnt, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    reset_ = 1'b1;

    // Threshold: three words stay parked, the fourth starts the burst.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("th_rden", {31'd0, rden}, 32'd0);
      chk("th_busy", {31'd0, busy}, 32'd0);
      tick();
    end
    load(1);
    tick();
    chk("th_start", {31'd0, busy}, 32'd1);
    wait_empty("th_drain", 60);
    chk("th_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("th_idle", {31'd0, busy}, 32'd0);

    // Backpressure with a 1,0,0,1 ready pattern.
    load(8);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      out_ready = pat[k % 4];
      tick();
    end
    chk("bp_drain", exp_q.size(), 32'd0);
    chk("bp_cnt", word_cnt, 32'd12);
    out_ready = 1'b1;
    tick();
    tick();
    chk("bp_idle", {31'd0, busy}, 32'd0);

    // Flush with a full skid buffer and a stalled sink.
    out_ready = 1'b0;
    load(12);
    repeat (8) tick();
    chk("fl_valid_pre", {31'd0, out_valid}, 32'd1);
    chk("fl_skid_full", {30'd0, dut.skid_cnt}, 32'd2);
    flushing = 1'b1;
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid_drop", {31'd0, out_valid}, 32'd0);
    wait_idle("fl_idle", 60);
    chk("fl_empty", {31'd0, rdempty}, 32'd1);
    chk("fl_cnt", word_cnt, 32'd12);
    exp_q.delete();
    rd_n = hs_n;
    flushing = 1'b0;

    // Flush held from IDLE keeps the block busy after the FIFO is drained.
    load(2);
    flushing = 1'b1;
    flush    = 1'b1;
    repeat (8) tick();
    chk("fh_busy", {31'd0, busy}, 32'd1);
    chk("fh_empty", {31'd0, rdempty}, 32'd1);
    flush = 1'b0;
    tick();
    chk("fh_idle", {31'd0, busy}, 32'd0);
    chk("fh_cnt", word_cnt, 32'd12);
    exp_q.delete();
    rd_n = hs_n;
    flushing = 1'b0;

    // Counter wrap.
    force dut.word_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.word_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    load(4);
    wait_empty("wr_drain", 60);
    chk("wr_cnt", word_cnt, 32'd3);
    tick();
    tick();

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ((wr_ptr - rd_ptr) < 16 && $urandom_range(0, 2) == 0) load(1);
      tick();
    end
    out_ready = 1'b1;
    repeat (10) tick();
    if (exp_q.size() != 0 && (wr_ptr - rd_ptr) < 4) load(4);
    wait_empty("rnd_drain", 200);
    wait_idle("rnd_idle", 20);

    // Asynchronous reset with a read in flight.
    load(6);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dut.rd_pend_q) break;
    end
    chk("mr_pend_seen", {31'd0, dut.rd_pend_q}, 32'd1);
    #2;
    reset_ = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_rden", {31'd0, rden}, 32'd0);
    chk("mr_cnt", word_cnt, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_pend", {31'd0, dut.rd_pend_q}, 32'd0);
    exp_q.delete();
    for (int i = rd_ptr; i < wr_ptr; i++) exp_q.push_back(mem[i]);
    n_rem = exp_q.size();
    tick();
    tick();
    reset_ = 1'b1;
    chk("mr_resume_idle", {31'd0, busy}, 32'd0);
    if (n_rem < 4) begin
      load(4);
      n_rem += 4;
    end
    wait_empty("mr_drain", 80);
    chk("mr_total", word_cnt, 32'(n_rem));
    wait_idle("mr_idle", 20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer for the team's asynch FIFO. It sits entirely in the FIFO read clock domain and drives the FIFO read port (rden, dataout, rdempty, rdusedw). It converts the FIFO's one-cycle registered read latency into a valid/ready stream for downstream MAC logic. Provides a start threshold (cut-through fill level), a 2-entry skid buffer, flush, and a delivered-word counter.

Parameters:
WIDTH, 8, data word width; must match the FIFO's WIDTH.
DEPTH, 16, FIFO depth; must match the FIFO's DEPTH.
PTR, 4, FIFO pointer width; rdusedw is PTR+1 bits.
START_THRESH, 4, minimum rdusedw (1..DEPTH) required to leave IDLE.

Ports:
clk  in  1  FIFO read clock (connects to the FIFO's rdclk)
reset_  in  1  asynchronous active-low reset
rden  out  1  read request to the FIFO
dataout  in  WIDTH  FIFO read data, valid the cycle after rden
rdempty  in  1  FIFO empty flag
rdusedw  in  PTR+1  FIFO fill level
flush  in  1  discard buffered words and drain the FIFO to empty
out_valid  out  1  stream word valid
out_data  out  WIDTH  stream word
out_ready  in  1  downstream accept
busy  out  1  state != IDLE
word_cnt  out  32  count of words accepted downstream (out_valid & out_ready), wraps

Behaviour:
- Reset (async, reset_=0):
  - state=IDLE; rden=0; out_valid=0; out_data=0; word_cnt=0; busy=0.
  - Skid buffer is empty; the in-flight flag is cleared.
- Reset mid-operation: all outputs go to reset values immediately. Any in-flight FIFO word is lost; FIFO contents are not this block's concern.
- FIFO read timing:
  - rden=1 in cycle N with rdempty=0 means dataout holds the word in cycle N+1.
  - The block captures dataout in cycle N+1 using a registered in-flight flag (rd_pend).
- rden is combinational from registered state only: rden = (state==RUN | state==FLUSH) & !rdempty & credit_ok.
  - rden is never asserted while rdempty=1.
- credit_ok in RUN: (buf_cnt + rd_pend + (wr into buffer this cycle) - (pop this cycle)) < 2.
  - Simpler legal form: buf_cnt + rd_pend < 2, evaluated on registered values. This guarantees no overflow.
- Skid buffer: 2 entries, FIFO order.
  - out_valid = (buf_cnt != 0); out_data = head entry.
  - Pop on out_valid & out_ready.
  - Push on rd_pend in RUN.
  - Simultaneous push and pop keeps buf_cnt unchanged.
- out_data/out_valid are stable while out_valid=1 & out_ready=0 (no drop, no reorder).
- States:
  - IDLE: rden=0. Goes to RUN when rdusedw >= START_THRESH. Goes to FLUSH when flush=1; flush has priority.
  - RUN: streams continuously. Goes to FLUSH on flush=1. Goes to IDLE when rdempty=1 & rd_pend=0 & buf_cnt=0; the threshold applies again for the next burst.
  - FLUSH:
    - buf_cnt forced to 0 on entry; out_valid=0.
    - rden = !rdempty (no credit limit); returning words are discarded.
    - Goes to IDLE when rdempty=1 & rd_pend=0 & flush=0.
    - flush held high keeps the block in FLUSH.
- word_cnt increments by 1 per handshake and wraps 2^32-1 -> 0. Flushed words are not counted.
- START_THRESH > DEPTH is illegal; IDLE would never exit. The implementation must flag this with a simulation-time check.
- rdusedw == DEPTH (FIFO full) is treated as an ordinary value >= threshold.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2);
  - the word-counter width constant (32).
- One sub-module: fifo_rd_skid2, the 2-entry skid buffer.
  - Ports: clk, reset_, clr, push, push_data, pop, out_valid, out_data, cnt.
- The top level holds the FSM, rden/credit logic, rd_pend and word_cnt.

Test Plan:
- Threshold: START_THRESH=4, FIFO model with a 1-cycle read latency. Load 3 words -> rden stays 0, busy=0. Add a 4th -> busy=1 next cycle; words D0..D3 appear in order with out_ready=1.
- Backpressure: 8 words queued, out_ready toggled 1,0,0,1 repeatedly.
  - Never more than 2 reads outstanding.
  - out_data stable while stalled.
  - All 8 words delivered in order; word_cnt=8.
- Empty boundary: stream until FIFO empty -> rden=0 whenever rdempty=1; block returns to IDLE one cycle after the last handshake.
- Flush: 10 words in FIFO, 2 in skid, pulse flush while out_ready=0.
  - out_valid drops next cycle.
  - FIFO drained to rdempty=1; state returns to IDLE.
  - word_cnt unchanged.
- Reset mid-stream: assert reset_=0 asynchronously between clock edges with rd_pend=1 -> out_valid=0, rden=0, word_cnt=0 immediately. Released reset resumes from IDLE.
- Counter wrap: preload word_cnt via force to 32'hFFFF_FFFF, then one handshake -> word_cnt=0.
